// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   - state_e       : sequencer FSM states
//   - OP_* / EXT_*  : opcode / opext values the sequencer itself acts on
//   - *_LSB/FIELD_W : bit positions of the 4-bit instruction fields
//   - is_no_writeback() : true for instructions that never write a register
// -----------------------------------------------------------------------------
package datapath_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_NOP   = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] EXT_CMP  = 4'hB;

  // Instruction word: [15:12] opcode, [11:8] Rdest, [7:4] opext/imm_hi, [3:0] Rsrc/imm_lo
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int EXT_LSB = 4;
  localparam int RS_LSB  = 0;

  // Compares only update flags (or do nothing), so they skip WRITEBACK.
  function automatic logic is_no_writeback(input logic [3:0] op, input logic [3:0] ext);
    logic res;
    res = 1'b0;
    if (op == OP_RTYPE && ext == EXT_CMP) begin
      res = 1'b1;
    end else if (op == OP_CMPI || op == OP_NOP) begin
      res = 1'b1;
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Bundle of the instruction handshake and regfile/ALU signals of the sequencer.
//   master : the sequencer (drives instr_ready, addresses, operands, write-back)
//   slave  : instruction source + regfile/ALU datapath
// Signals: instr_valid/instr/instr_ready, rd1/rd2/alu_result, opcode/opext,
//          ra1/ra2/wa, regwrite/wd, Rdest/Rsrc, busy.
// -----------------------------------------------------------------------------
interface datapath_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic               instr_valid;
  logic [15:0]        instr;
  logic               instr_ready;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic [WIDTH-1:0]   alu_result;
  logic [3:0]         opcode;
  logic [3:0]         opext;
  logic [REGBITS-1:0] ra1;
  logic [REGBITS-1:0] ra2;
  logic [REGBITS-1:0] wa;
  logic               regwrite;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   Rdest;
  logic [WIDTH-1:0]   Rsrc;
  logic               busy;

  modport master (
    input  instr_valid, instr, rd1, rd2, alu_result,
    output instr_ready, opcode, opext, ra1, ra2, wa, regwrite, wd, Rdest, Rsrc, busy
  );

  modport slave (
    output instr_valid, instr, rd1, rd2, alu_result,
    input  instr_ready, opcode, opext, ra1, ra2, wa, regwrite, wd, Rdest, Rsrc, busy
  );
endinterface

// File: rtl/datapath_sequencer_instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Combinational split of the latched instruction word.
//   ir_i        : instruction register
//   opcode_o    : [15:12]            rdest_o : [11:8]
//   opext_o     : [7:4]              rsrc_o  : [3:0]
//   imm_sext_o  : [7:0] sign-extended to WIDTH
//   is_rtype_o  : opcode is register-register
//   no_wb_o     : instruction skips WRITEBACK (CMP, CMPI, NOP)
// -----------------------------------------------------------------------------
module instr_field_decode
  import datapath_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      ir_i,
  output logic [3:0]       opcode_o,
  output logic [3:0]       rdest_o,
  output logic [3:0]       opext_o,
  output logic [3:0]       rsrc_o,
  output logic [WIDTH-1:0] imm_sext_o,
  output logic             is_rtype_o,
  output logic             no_wb_o
);
  logic [7:0] imm8_s;

  assign opcode_o   = ir_i[OPC_LSB +: FIELD_W];
  assign rdest_o    = ir_i[RD_LSB  +: FIELD_W];
  assign opext_o    = ir_i[EXT_LSB +: FIELD_W];
  assign rsrc_o     = ir_i[RS_LSB  +: FIELD_W];
  // I-type immediate reuses the opext and Rsrc nibbles.
  assign imm8_s     = {opext_o, rsrc_o};
  assign imm_sext_o = {{(WIDTH-8){imm8_s[7]}}, imm8_s};
  assign is_rtype_o = (opcode_o == OP_RTYPE);
  assign no_wb_o    = is_no_writeback(opcode_o, opext_o);
endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 16-bit
// regfile/ALU datapath. One instruction in flight; no overlap.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : datapath_sequencer_if.master (handshake, regfile, ALU signals)
//   retired: retired-instruction counter, present only when
//            DATAPATH_SEQUENCER_RETIRE_COUNT_EN is defined
// REGBITS must be 4: the register fields in the instruction are fixed 4-bit.
// -----------------------------------------------------------------------------
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic clk,
  input  logic reset,
  datapath_sequencer_if.master bus
`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);
  state_e           state_q;
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] rdest_q;
  logic [WIDTH-1:0] rsrc_q;
  logic [WIDTH-1:0] wd_q;
  logic             regwrite_q;
  logic             busy_q;
  logic             ready_q;

  logic [3:0]       dec_opcode_s;
  logic [3:0]       dec_rdest_s;
  logic [3:0]       dec_opext_s;
  logic [3:0]       dec_rsrc_s;
  logic [WIDTH-1:0] dec_imm_s;
  logic             dec_is_rtype_s;
  logic             dec_no_wb_s;

  instr_field_decode #(.WIDTH(WIDTH)) u_decode (
    .ir_i       (ir_q),
    .opcode_o   (dec_opcode_s),
    .rdest_o    (dec_rdest_s),
    .opext_o    (dec_opext_s),
    .rsrc_o     (dec_rsrc_s),
    .imm_sext_o (dec_imm_s),
    .is_rtype_o (dec_is_rtype_s),
    .no_wb_o    (dec_no_wb_s)
  );

  // Sequencer FSM with registered outputs; ready_q is 1 in reset so FETCH
  // can accept in the very first cycle, the pin gating below hides it meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      ir_q       <= 16'h0000;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      wd_q       <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.instr_valid && ready_q) begin
            ir_q    <= bus.instr;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_DECODE;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          rdest_q <= bus.rd1;
          rsrc_q  <= dec_is_rtype_s ? bus.rd2 : dec_imm_s;
          state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          wd_q <= bus.alu_result;
          if (dec_no_wb_s) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            regwrite_q <= 1'b1;
            state_q    <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          regwrite_q <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= ST_FETCH;
        end
        default: begin
          regwrite_q <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= ST_FETCH;
        end
      endcase
    end
  end

  // Addresses and ALU control come straight from the instruction register,
  // so they only change on an accepted handshake.
  assign bus.instr_ready = ready_q & reset;
  assign bus.busy        = busy_q;
  assign bus.opcode      = dec_opcode_s;
  assign bus.opext       = dec_opext_s;
  assign bus.ra1         = dec_rdest_s;
  assign bus.ra2         = dec_rsrc_s;
  assign bus.wa          = dec_rdest_s;
  assign bus.regwrite    = regwrite_q;
  assign bus.wd          = wd_q;
  assign bus.Rdest       = rdest_q;
  assign bus.Rsrc        = rsrc_q;

`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
  logic        retire_s;
  logic [15:0] retired_q;
  logic [15:0] retired_d;

  // An instruction retires when it leaves WRITEBACK, or EXECUTE if it has no write-back.
  always_comb begin
    retire_s = 1'b0;
    if (state_q == ST_WRITEBACK) begin
      retire_s = 1'b1;
    end else if (state_q == ST_EXECUTE && dec_no_wb_s) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
    retired_d = retire_s ? (retired_q + 16'd1) : retired_q;
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Directed, table-driven bench for datapath_sequencer with a read-only
// regfile model (r1=0x0005, r2=0x0003, r3=0x1234, r7=0x8000) and an ALU
// model returning Rdest+Rsrc. Define DATAPATH_SEQUENCER_RETIRE_COUNT_EN to
// also exercise the retired counter.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;
  logic clk;
  logic reset;
  logic [15:0] rf [16];
`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  int pass_cnt;
  int total_cnt;

  datapath_sequencer_if #(.WIDTH(16), .REGBITS(4)) bus ();

  datapath_sequencer #(.WIDTH(16), .REGBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
    ,
    .retired (retired)
`endif
  );

  assign bus.rd1        = rf[bus.ra1];
  assign bus.rd2        = rf[bus.ra2];
  assign bus.alu_result = bus.Rdest + bus.Rsrc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [3:0]  ext;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] rdest;
    logic [15:0] rsrc;
    logic        wb;
    logic [3:0]  wa;
    logic [15:0] wd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends just after a negedge, with the DUT in FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    bus.instr       = v.instr;
    bus.instr_valid = 1'b1;
    chk($sformatf("v%0d fetch ready", idx), {15'd0, bus.instr_ready}, 16'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d decode ready", idx), {15'd0, bus.instr_ready}, 16'd0);
    chk($sformatf("v%0d decode busy", idx), {15'd0, bus.busy}, 16'd1);
    chk($sformatf("v%0d ra1", idx), {12'd0, bus.ra1}, {12'd0, v.ra1});
    chk($sformatf("v%0d ra2", idx), {12'd0, bus.ra2}, {12'd0, v.ra2});
    chk($sformatf("v%0d opcode", idx), {12'd0, bus.opcode}, {12'd0, v.op});
    chk($sformatf("v%0d opext", idx), {12'd0, bus.opext}, {12'd0, v.ext});
    @(negedge clk);
    chk($sformatf("v%0d Rdest", idx), bus.Rdest, v.rdest);
    chk($sformatf("v%0d Rsrc", idx), bus.Rsrc, v.rsrc);
    chk($sformatf("v%0d exec regwrite", idx), {15'd0, bus.regwrite}, 16'd0);
    @(negedge clk);
    if (v.wb) begin
      chk($sformatf("v%0d wb regwrite", idx), {15'd0, bus.regwrite}, 16'd1);
      chk($sformatf("v%0d wa", idx), {12'd0, bus.wa}, {12'd0, v.wa});
      chk($sformatf("v%0d wd", idx), bus.wd, v.wd);
      chk($sformatf("v%0d wb ready", idx), {15'd0, bus.instr_ready}, 16'd0);
      @(negedge clk);
    end
    chk($sformatf("v%0d done ready", idx), {15'd0, bus.instr_ready}, 16'd1);
    chk($sformatf("v%0d done busy", idx), {15'd0, bus.busy}, 16'd0);
    chk($sformatf("v%0d done regwrite", idx), {15'd0, bus.regwrite}, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rf[1] = 16'h0005;
    rf[2] = 16'h0003;
    rf[3] = 16'h1234;
    rf[7] = 16'h8000;

    //           instr     op     ext    ra1    ra2    Rdest      Rsrc       wb    wa     wd
    vecs[0] = '{16'h0152, 4'h0, 4'h5, 4'h1, 4'h2, 16'h0005, 16'h0003, 1'b1, 4'h1, 16'h0008}; // ADD
    vecs[1] = '{16'h51FF, 4'h5, 4'hF, 4'h1, 4'hF, 16'h0005, 16'hFFFF, 1'b1, 4'h1, 16'h0004}; // ADDI -1
    vecs[2] = '{16'h01B2, 4'h0, 4'hB, 4'h1, 4'h2, 16'h0005, 16'h0003, 1'b0, 4'h1, 16'h0000}; // CMP
    vecs[3] = '{16'hB27F, 4'hB, 4'h7, 4'h2, 4'hF, 16'h0003, 16'h007F, 1'b0, 4'h2, 16'h0000}; // CMPI
    vecs[4] = '{16'h4312, 4'h4, 4'h1, 4'h3, 4'h2, 16'h1234, 16'h0012, 1'b0, 4'h3, 16'h0000}; // NOP
    vecs[5] = '{16'h0371, 4'h0, 4'h7, 4'h3, 4'h1, 16'h1234, 16'h0005, 1'b1, 4'h3, 16'h1239}; // R-type
    vecs[6] = '{16'hE780, 4'hE, 4'h8, 4'h7, 4'h0, 16'h8000, 16'hFF80, 1'b1, 4'h7, 16'h7F80}; // I-type neg imm

    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    reset           = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst ready", {15'd0, bus.instr_ready}, 16'd0);
    chk("rst busy", {15'd0, bus.busy}, 16'd0);
    chk("rst regwrite", {15'd0, bus.regwrite}, 16'd0);
    chk("rst wd", bus.wd, 16'h0000);
    chk("rst Rsrc", bus.Rsrc, 16'h0000);
`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
    chk("rst retired", retired, 16'h0000);
`endif
    reset = 1'b1;
    #1;
    chk("post-rst ready", {15'd0, bus.instr_ready}, 16'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Idle in FETCH: nothing moves
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle busy", {15'd0, bus.busy}, 16'd0);
      chk("idle ready", {15'd0, bus.instr_ready}, 16'd1);
      chk("idle regwrite", {15'd0, bus.regwrite}, 16'd0);
      chk("idle ra1", {12'd0, bus.ra1}, 16'h0007);
      chk("idle Rsrc", bus.Rsrc, 16'hFF80);
      chk("idle wd", bus.wd, 16'h7F80);
    end
    run_vec(10, vecs[0]);

    // instr_valid held high while busy is ignored
    bus.instr       = 16'h0152;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr = 16'hE780;
    @(negedge clk);
    chk("ign decode ready", {15'd0, bus.instr_ready}, 16'd0);
    @(negedge clk);
    chk("ign exec ra1", {12'd0, bus.ra1}, 16'h0001);
    chk("ign exec Rsrc", bus.Rsrc, 16'h0003);
    @(negedge clk);
    chk("ign wb regwrite", {15'd0, bus.regwrite}, 16'd1);
    chk("ign wb wd", bus.wd, 16'h0008);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("ign back ready", {15'd0, bus.instr_ready}, 16'd1);
    chk("ign back ra1", {12'd0, bus.ra1}, 16'h0001);

    // Reset during EXECUTE abandons the instruction
    bus.instr       = 16'h0152;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid exec busy", {15'd0, bus.busy}, 16'd1);
    reset = 1'b0;
    #1;
    chk("mid rst regwrite", {15'd0, bus.regwrite}, 16'd0);
    chk("mid rst busy", {15'd0, bus.busy}, 16'd0);
    chk("mid rst ready", {15'd0, bus.instr_ready}, 16'd0);
    chk("mid rst Rdest", bus.Rdest, 16'h0000);
    chk("mid rst ra1", {12'd0, bus.ra1}, 16'h0000);
    @(posedge clk);
    #1;
    chk("mid rst held regwrite", {15'd0, bus.regwrite}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel ready", {15'd0, bus.instr_ready}, 16'd1);
    chk("rel busy", {15'd0, bus.busy}, 16'd0);
    chk("rel wd", bus.wd, 16'h0000);
    @(posedge clk);
    #1;
    chk("rel regwrite", {15'd0, bus.regwrite}, 16'd0);
    @(negedge clk);
    run_vec(20, vecs[1]);

`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
    do_reset();
    chk("ret after rst", retired, 16'h0000);
    run_vec(30, vecs[0]);
    run_vec(31, vecs[2]);
    run_vec(32, vecs[1]);
    chk("ret three", retired, 16'h0003);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    @(negedge clk);
    chk("ret forced", retired, 16'hFFFF);
    run_vec(33, vecs[2]);
    chk("ret wrap", retired, 16'h0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
